// File: rtl/sistema_de_escritura.sv
// rtl/sistema_de_escritura.sv - multiplexed 7-segment hex display with single-word shadow handshake
//
// Purpose:
//   Scans WIDTH active-low 7-segment digits, one digit slot every REFRESH_DIV
//   clocks. A producer hands over a display word through a valid/ready
//   handshake into a single shadow register; the word is committed to the
//   display only at a digit-slot boundary so a word never changes mid-slot.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_valid  producer offers a new display word
//   data        4*WIDTH bits of hex nibbles, nibble 0 is the rightmost digit
//   data_ready  registered, high when the shadow register is free
//   blank_lz    leading-zero blanking enable, sampled at each slot boundary
//   anodo       active-low one-hot digit enables, registered
//   seg         active-low segments {g,f,e,d,c,b,a}, registered

module sistema_de_escritura #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 27000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_valid,
  input  logic [4*WIDTH-1:0]   data,
  output logic                 data_ready,
  input  logic                 blank_lz,
  output logic [WIDTH-1:0]     anodo,
  output logic [6:0]           seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [4*WIDTH-1:0] display;
  logic [4*WIDTH-1:0] shadow;
  logic [4*WIDTH-1:0] display_next;
  logic [4*WIDTH-1:0] shifted;
  logic               pending;
  logic               tick;
  logic               capture;
  logic               blank;
  logic [6:0]         seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick    = (cnt == CW'(REFRESH_DIV - 1));
  assign capture = data_valid && data_ready;

  // Value the display register holds after this edge; the digit loaded on a
  // tick must reflect a transfer happening on that same tick. A capture on
  // the tick edge cannot transfer here because pending is still clear.
  assign display_next = (tick && pending) ? shadow : display;

  // idx is the digit selected on the coming tick. A digit is a leading zero
  // when it and every nibble above it are zero; digit 0 is never blanked.
  always_comb begin
    shifted  = display_next >> {idx, 2'b00};
    blank    = blank_lz && (idx != '0) && (shifted == '0);
    seg_next = blank ? 7'h7F : hex7(shifted[3:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      display    <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      data_ready <= 1'b1;
      anodo      <= '1;
      seg        <= 7'h7F;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;

      // Capture needs ready (pending clear), transfer needs pending set, so
      // the two never coincide.
      if (capture) begin
        shadow     <= data;
        pending    <= 1'b1;
        data_ready <= 1'b0;
      end else if (tick && pending) begin
        display    <= shadow;
        pending    <= 1'b0;
        data_ready <= 1'b1;
      end

      if (tick) begin
        anodo <= ~(WIDTH'(1) << idx);
        seg   <= seg_next;
        idx   <= (idx == IW'(WIDTH - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule
